// File: rtl/wqe_fetch_scheduler_if.sv
// Grant handshake bundle between the per-QP WQE caches, the scheduler and the fetch engine.
// i_qp_weight exists only when WQE_SCHED_WEIGHT_EN is defined.
interface wqe_fetch_scheduler_if #(
    parameter int MAX_QP       = 16,
    parameter int QP_PTR_WIDTH = 4
`ifdef WQE_SCHED_WEIGHT_EN
    ,
    parameter int WEIGHT_WIDTH = 4
`endif
);
    logic [MAX_QP-1:0]              i_active;
    logic [MAX_QP-1:0]              i_wqe_cache_alfull;
    logic                           i_fetch_ready;
    logic                           o_sched_val;
    logic [QP_PTR_WIDTH-1:0]        o_qp_idx;
    logic [MAX_QP-1:0]              o_qp_idx_one_hot;
    logic                           o_no_eligible;
`ifdef WQE_SCHED_WEIGHT_EN
    logic [MAX_QP*WEIGHT_WIDTH-1:0] i_qp_weight;
`endif

    modport master (
`ifdef WQE_SCHED_WEIGHT_EN
        input  i_qp_weight,
`endif
        input  i_active,
        input  i_wqe_cache_alfull,
        input  i_fetch_ready,
        output o_sched_val,
        output o_qp_idx,
        output o_qp_idx_one_hot,
        output o_no_eligible
    );

    modport slave (
`ifdef WQE_SCHED_WEIGHT_EN
        output i_qp_weight,
`endif
        output i_active,
        output i_wqe_cache_alfull,
        output i_fetch_ready,
        input  o_sched_val,
        input  o_qp_idx,
        input  o_qp_idx_one_hot,
        input  o_no_eligible
    );
endinterface

// File: rtl/wqe_fetch_scheduler.sv
// Rotating-priority round-robin WQE fetch scheduler with registered valid/ready grant and stale-grant revocation.
// Optional weighted burst mode is enabled by defining WQE_SCHED_WEIGHT_EN.
module wqe_fetch_scheduler #(
    parameter int MAX_QP       = 16,
    parameter int QP_PTR_WIDTH = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    wqe_fetch_scheduler_if.master sif
);
    // state | meaning
    // IDLE  | nothing eligible, waiting
    // ARB   | pick next eligible QP upward from ptr
    // OFFER | grant presented, waiting for ready or revocation
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        OFFER = 2'd2
    } state_e;

    if (MAX_QP < 2 || MAX_QP > 64 || (1 << QP_PTR_WIDTH) < MAX_QP || WEIGHT_WIDTH < 1) begin : g_bad_params
        $error("wqe_fetch_scheduler: illegal parameter combination");
    end

    localparam logic [QP_PTR_WIDTH-1:0] LAST_QP = QP_PTR_WIDTH'(MAX_QP - 1);

    state_e                  state_q, state_d;
    logic [QP_PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic [QP_PTR_WIDTH-1:0] idx_q, idx_d;
    logic [MAX_QP-1:0]       oh_q, oh_d;
    logic                    no_elig_q;

    logic [MAX_QP-1:0]       elig;
    logic [MAX_QP-1:0]       upper_mask;
    logic [MAX_QP-1:0]       upper_elig;
    logic [MAX_QP-1:0]       hi_oh, lo_oh, arb_oh;
    logic [QP_PTR_WIDTH-1:0] hi_idx, lo_idx, arb_idx;
    logic [QP_PTR_WIDTH-1:0] ptr_next;
    logic                    hi_found;
    logic                    any_elig;
    logic                    grant_elig;
    logic                    handshake;

    assign elig       = sif.i_active & ~sif.i_wqe_cache_alfull;
    assign any_elig   = |elig;
    assign grant_elig = |(elig & oh_q);
    assign handshake  = (state_q == OFFER) && sif.i_fetch_ready;
    assign ptr_next   = (idx_q == LAST_QP) ? '0 : idx_q + QP_PTR_WIDTH'(1);

    // Split search: lowest eligible at or above ptr, else lowest eligible overall (wrap).
    always_comb begin
        upper_mask = '0;
        hi_found   = 1'b0;
        hi_idx     = '0;
        hi_oh      = '0;
        lo_idx     = '0;
        lo_oh      = '0;
        for (int i = 0; i < MAX_QP; i++) begin
            upper_mask[i] = (QP_PTR_WIDTH'(i) >= ptr_q);
        end
        upper_elig = elig & upper_mask;
        for (int i = MAX_QP - 1; i >= 0; i--) begin
            if (upper_elig[i]) begin
                hi_found  = 1'b1;
                hi_idx    = QP_PTR_WIDTH'(i);
                hi_oh     = '0;
                hi_oh[i]  = 1'b1;
            end
            if (elig[i]) begin
                lo_idx    = QP_PTR_WIDTH'(i);
                lo_oh     = '0;
                lo_oh[i]  = 1'b1;
            end
        end
        arb_idx = hi_found ? hi_idx : lo_idx;
        arb_oh  = hi_found ? hi_oh  : lo_oh;
    end

`ifdef WQE_SCHED_WEIGHT_EN
    logic [WEIGHT_WIDTH-1:0] burst_q, burst_d;
    logic [WEIGHT_WIDTH-1:0] arb_weight;

    always_comb begin
        arb_weight = '0;
        for (int i = 0; i < MAX_QP; i++) begin
            if (arb_oh[i]) begin
                arb_weight = sif.i_qp_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
`ifdef WQE_SCHED_WEIGHT_EN
        burst_d = burst_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (any_elig) begin
                    idx_d   = arb_idx;
                    oh_d    = arb_oh;
                    state_d = OFFER;
`ifdef WQE_SCHED_WEIGHT_EN
                    // Weight 0 behaves like weight 1: a single grant.
                    burst_d = (arb_weight == '0) ? '0 : arb_weight - WEIGHT_WIDTH'(1);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (handshake) begin
`ifdef WQE_SCHED_WEIGHT_EN
                    if (burst_q != '0 && grant_elig) begin
                        burst_d = burst_q - WEIGHT_WIDTH'(1);
                    end else begin
`else
                    begin
`endif
                        ptr_d   = ptr_next;
                        state_d = any_elig ? ARB : IDLE;
                    end
                end else if (!grant_elig) begin
                    // Stale grant: withdraw without moving the pointer.
                    state_d = ARB;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            oh_q      <= '0;
            no_elig_q <= 1'b1;
`ifdef WQE_SCHED_WEIGHT_EN
            burst_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            oh_q      <= oh_d;
            no_elig_q <= ~any_elig;
`ifdef WQE_SCHED_WEIGHT_EN
            burst_q   <= burst_d;
`endif
        end
    end

    assign sif.o_sched_val      = (state_q == OFFER);
    assign sif.o_qp_idx         = idx_q;
    assign sif.o_qp_idx_one_hot = oh_q;
    assign sif.o_no_eligible    = no_elig_q;

endmodule

// File: tb/tb_wqe_fetch_scheduler.sv
// Scoreboard bench for wqe_fetch_scheduler: a 16-QP and a 5-QP instance share clock and reset.
// Build with WQE_SCHED_WEIGHT_EN defined to also exercise weighted bursts.
module tb_wqe_fetch_scheduler;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    wqe_fetch_scheduler_if #(.MAX_QP(16), .QP_PTR_WIDTH(4)) sif16 ();
    wqe_fetch_scheduler_if #(.MAX_QP(5),  .QP_PTR_WIDTH(3)) sif5 ();

    wqe_fetch_scheduler #(.MAX_QP(16), .QP_PTR_WIDTH(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .sif (sif16)
    );

    wqe_fetch_scheduler #(.MAX_QP(5), .QP_PTR_WIDTH(3)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .sif (sif5)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sif16.i_active = '0;
        sif16.i_wqe_cache_alfull = '0;
        sif16.i_fetch_ready = 1'b1;
        sif5.i_active = '0;
        sif5.i_wqe_cache_alfull = '0;
        sif5.i_fetch_ready = 1'b1;
`ifdef WQE_SCHED_WEIGHT_EN
        sif16.i_qp_weight = '0;
        sif5.i_qp_weight = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (sif16.o_sched_val !== 1'b0) begin failures++; $display("FAIL reset_val: got %b expected 0", sif16.o_sched_val); end
        if (sif16.o_qp_idx !== 4'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", sif16.o_qp_idx); end
        if (sif16.o_qp_idx_one_hot !== 16'h0000) begin failures++; $display("FAIL reset_oh: got %h expected 0000", sif16.o_qp_idx_one_hot); end
        if (sif16.o_no_eligible !== 1'b1) begin failures++; $display("FAIL reset_no_elig: got %b expected 1", sif16.o_no_eligible); end
        if (sif5.o_sched_val !== 1'b0) begin failures++; $display("FAIL reset_val5: got %b expected 0", sif5.o_sched_val); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks += 2;
            if (sif16.o_sched_val !== 1'b0) begin failures++; $display("FAIL idle_val: cycle %0d got %b expected 0", c, sif16.o_sched_val); end
            if (sif16.o_no_eligible !== 1'b1) begin failures++; $display("FAIL idle_no_elig: cycle %0d got %b expected 1", c, sif16.o_no_eligible); end
        end
    endtask

    task automatic test_round_robin();
        int e;
        int last;
        logic [15:0] e_oh;
        do_reset();
        sif16.i_active = 16'h0421;
        @(negedge clk);
        checks += 2;
        if (sif16.o_sched_val !== 1'b0) begin failures++; $display("FAIL rr_latency_early: got %b expected 0", sif16.o_sched_val); end
        if (sif16.o_no_eligible !== 1'b0) begin failures++; $display("FAIL rr_no_elig: got %b expected 0", sif16.o_no_eligible); end
        @(negedge clk);
        checks++;
        if (sif16.o_sched_val !== 1'b1) begin failures++; $display("FAIL rr_latency: got %b expected 1", sif16.o_sched_val); end
        exp_q = '{0, 5, 10, 0, 5, 10};
        last = -1;
        for (int b = 0; b < 40 && exp_q.size() > 0; b++) begin
            if (sif16.o_sched_val === 1'b1) begin
                e = exp_q.pop_front();
                e_oh = 16'(1) << e;
                checks += 2;
                if (sif16.o_qp_idx !== 4'(e)) begin failures++; $display("FAIL rr_idx: got %0d expected %0d", sif16.o_qp_idx, e); end
                if (sif16.o_qp_idx_one_hot !== e_oh) begin failures++; $display("FAIL rr_oh: got %h expected %h", sif16.o_qp_idx_one_hot, e_oh); end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin failures++; $display("FAIL rr_gap: got %0d expected 2", cyc - last); end
                end
                last = cyc;
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rr_timeout: %0d grants missing, expected 0", exp_q.size()); end
        sif16.i_active = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_alfull_revoke();
        int e;
        bit seen;
        do_reset();
        sif16.i_active = 16'hFFFF;
        sif16.i_wqe_cache_alfull = 16'hFFFE;
        exp_q = '{0, 0, 0};
        for (int b = 0; b < 30 && exp_q.size() > 0; b++) begin
            if (sif16.o_sched_val === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (sif16.o_qp_idx !== 4'(e)) begin failures++; $display("FAIL alfull_idx: got %0d expected %0d", sif16.o_qp_idx, e); end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL alfull_timeout: %0d grants missing, expected 0", exp_q.size()); end

        do_reset();
        sif16.i_fetch_ready = 1'b0;
        sif16.i_active = 16'hFFFF;
        sif16.i_wqe_cache_alfull = 16'hFFFE;
        seen = 1'b0;
        for (int b = 0; b < 10 && !seen; b++) begin
            @(negedge clk);
            seen = (sif16.o_sched_val === 1'b1);
        end
        checks += 2;
        if (!seen) begin failures++; $display("FAIL revoke_offer_timeout: got no offer, expected offer"); end
        if (sif16.o_qp_idx !== 4'd0) begin failures++; $display("FAIL revoke_offer_idx: got %0d expected 0", sif16.o_qp_idx); end
        sif16.i_wqe_cache_alfull = 16'hFFFF;
        @(negedge clk);
        checks += 3;
        if (sif16.o_sched_val !== 1'b0) begin failures++; $display("FAIL revoke_val: got %b expected 0", sif16.o_sched_val); end
        if (sif16.o_no_eligible !== 1'b1) begin failures++; $display("FAIL revoke_no_elig: got %b expected 1", sif16.o_no_eligible); end
        if (sif16.o_qp_idx !== 4'd0) begin failures++; $display("FAIL revoke_hold_idx: got %0d expected 0", sif16.o_qp_idx); end
        // Pointer must not have moved, so QP0 wins again with everything eligible.
        sif16.i_wqe_cache_alfull = 16'h0000;
        sif16.i_fetch_ready = 1'b1;
        exp_q = '{0};
        for (int b = 0; b < 10 && exp_q.size() > 0; b++) begin
            if (sif16.o_sched_val === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (sif16.o_qp_idx !== 4'(e)) begin failures++; $display("FAIL revoke_ptr_idx: got %0d expected %0d", sif16.o_qp_idx, e); end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL revoke_timeout: %0d grants missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap_np2();
        int e;
        logic [4:0] e_oh;
        bit first;
        do_reset();
        sif5.i_active = 5'b01000;
        exp_q = '{3, 4, 0, 4, 0};
        first = 1'b1;
        for (int b = 0; b < 40 && exp_q.size() > 0; b++) begin
            if (sif5.o_sched_val === 1'b1) begin
                e = exp_q.pop_front();
                e_oh = 5'(1) << e;
                checks += 3;
                if (sif5.o_qp_idx !== 3'(e)) begin failures++; $display("FAIL wrap_idx: got %0d expected %0d", sif5.o_qp_idx, e); end
                if (sif5.o_qp_idx_one_hot !== e_oh) begin failures++; $display("FAIL wrap_oh: got %b expected %b", sif5.o_qp_idx_one_hot, e_oh); end
                if (sif5.o_qp_idx > 3'd4) begin failures++; $display("FAIL wrap_range: got %0d expected <= 4", sif5.o_qp_idx); end
                if (first) begin
                    sif5.i_active = 5'b10001;
                    first = 1'b0;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_timeout: %0d grants missing, expected 0", exp_q.size()); end
        sif5.i_active = '0;
        repeat (3) @(negedge clk);
    endtask

`ifdef WQE_SCHED_WEIGHT_EN
    task automatic test_weighted_burst();
        int e;
        int n;
        int last;
        int gaps[7];
        gaps = '{1, 1, 2, 2, 1, 1, 2};
        do_reset();
        sif16.i_qp_weight[1*4 +: 4] = 4'd3;
        sif16.i_qp_weight[2*4 +: 4] = 4'd1;
        sif16.i_active = 16'h0006;
        exp_q = '{1, 1, 1, 2, 1, 1, 1, 2};
        n = 0;
        last = 0;
        for (int b = 0; b < 60 && exp_q.size() > 0; b++) begin
            if (sif16.o_sched_val === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (sif16.o_qp_idx !== 4'(e)) begin failures++; $display("FAIL burst_idx: grant %0d got %0d expected %0d", n, sif16.o_qp_idx, e); end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != gaps[n-1]) begin failures++; $display("FAIL burst_gap: grant %0d got %0d expected %0d", n, cyc - last, gaps[n-1]); end
                end
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL burst_timeout: %0d grants missing, expected 0", exp_q.size()); end
        sif16.i_active = '0;
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_offer();
        int e;
        bit seen;
        do_reset();
        sif16.i_fetch_ready = 1'b0;
        sif16.i_active = 16'h0030;
        seen = 1'b0;
        for (int b = 0; b < 10 && !seen; b++) begin
            @(negedge clk);
            seen = (sif16.o_sched_val === 1'b1);
        end
        checks += 2;
        if (!seen) begin failures++; $display("FAIL midrst_offer_timeout: got no offer, expected offer"); end
        if (sif16.o_qp_idx !== 4'd4) begin failures++; $display("FAIL midrst_offer_idx: got %0d expected 4", sif16.o_qp_idx); end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (sif16.o_sched_val !== 1'b0) begin failures++; $display("FAIL midrst_val: got %b expected 0", sif16.o_sched_val); end
        if (sif16.o_qp_idx !== 4'd0) begin failures++; $display("FAIL midrst_idx: got %0d expected 0", sif16.o_qp_idx); end
        if (sif16.o_qp_idx_one_hot !== 16'h0000) begin failures++; $display("FAIL midrst_oh: got %h expected 0000", sif16.o_qp_idx_one_hot); end
        if (sif16.o_no_eligible !== 1'b1) begin failures++; $display("FAIL midrst_no_elig: got %b expected 1", sif16.o_no_eligible); end
        @(negedge clk);
        rst = 1'b0;
        sif16.i_active = 16'h0008;
        sif16.i_fetch_ready = 1'b1;
        exp_q = '{3};
        @(negedge clk);
        checks++;
        if (sif16.o_sched_val !== 1'b0) begin failures++; $display("FAIL midrst_latency_early: got %b expected 0", sif16.o_sched_val); end
        @(negedge clk);
        checks += 3;
        if (sif16.o_sched_val !== 1'b1) begin
            failures++;
            $display("FAIL midrst_latency: got %b expected 1", sif16.o_sched_val);
        end else begin
            e = exp_q.pop_front();
            if (sif16.o_qp_idx !== 4'(e)) begin failures++; $display("FAIL midrst_first_idx: got %0d expected %0d", sif16.o_qp_idx, e); end
            if (sif16.o_qp_idx_one_hot !== (16'(1) << e)) begin failures++; $display("FAIL midrst_first_oh: got %h expected %h", sif16.o_qp_idx_one_hot, 16'(1) << e); end
        end
        sif16.i_active = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_round_robin();
        test_alfull_revoke();
        test_wrap_np2();
`ifdef WQE_SCHED_WEIGHT_EN
        test_weighted_burst();
`endif
        test_reset_mid_offer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
